fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction-fetch stage that drives the producer side of the IF/ID pipeline register. Owns the PC, issues word reads on the instruction-memory handshake, buffers each returned instruction together with its PC, PC+4, predicted next PC and predicted direction, and presents them to IF/ID until accepted. It applies a static BTFN/JAL prediction and handles redirects from EX, including redirects that arrive while a memory read is outstanding.

## Interface
- RESET_PC, 32'h60, PC fetched first after reset
- PREDICT_EN, 1, 1 = static prediction enabled; 0 = always predict PC+4, not taken
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- imem_read  out  1  read request; held high until imem_resp
- imem_address  out  32  word address of request; stable while imem_read=1
- imem_resp  in  1  one-cycle pulse; imem_rdata valid this cycle
- imem_rdata  in  32  instruction word
- ifid_en  in  1  IF/ID load enable from hazard unit (consumer accept)
- redirect  in  1  EX mispredict / jalr resolve: refetch from redirect_pc
- redirect_pc  in  32  corrected PC
- fetch_valid  out  1  buffered instruction valid for IF/ID
- fetch_pc  out  32  PC of buffered instruction
- fetch_pc_plus4  out  32  fetch_pc + 4
- fetch_next_pc  out  32  predicted successor PC
- fetch_rdata  out  32  instruction word
- fetch_predicted_direction  out  1  1 = predicted taken

## Operation
- Registers: pc, pending_pc, output buffer (pc, pc_plus4, next_pc, rdata, pred), state.
- Reset (rst=1 at edge): state=REQ, pc=RESET_PC; buffer pc=RESET_PC, pc_plus4=RESET_PC+4, next_pc=RESET_PC+4, rdata=0, pred=0. During the reset cycle imem_read=0, fetch_valid=0.
- imem_address = pc in REQ, pending-request address (old pc) in DROP. imem_read=1 in REQ and DROP, 0 in HELD.
- fetch_valid = (state==HELD) && !redirect.
- Prediction on imem_rdata at capture: opcode 7'b1100011 with b_imm[12]=1 -> taken, next_pc = pc + sext(b_imm); opcode 7'b1101111 -> taken, next_pc = pc + sext(j_imm); all others (incl. JALR, forward branches) -> not taken, next_pc = pc+4. PREDICT_EN=0 forces not-taken/pc+4. All adds modulo 2^32, wrap silently.
- State REQ:
  - redirect && imem_resp: discard data, pc<=redirect_pc, stay REQ.
  - redirect && !imem_resp: pending_pc<=redirect_pc, -> DROP (address frozen).
  - imem_resp only: capture buffer from pc/imem_rdata, -> HELD.
- State HELD:
  - redirect: pc<=redirect_pc, -> REQ (buffer contents ignored).
  - ifid_en: pc<=buffer next_pc, -> REQ.
  - else hold all.
- State DROP:
  - imem_resp: discard data; pc<=(redirect ? redirect_pc : pending_pc), -> REQ.
  - redirect without resp: pending_pc<=redirect_pc, stay.
- redirect has priority over ifid_en and imem_resp in every state.
- ifid_en is ignored outside HELD (hazard unit must flush IF/ID when fetch_valid=0).

## Timing
- First request: cycle after rst deasserts, imem_read=1, imem_address=RESET_PC.
- imem_resp in cycle N -> fetch_valid=1 in N+1; accepted with ifid_en in N+1 -> next request address in N+2. Peak throughput: 1 instruction / 2 cycles with single-cycle memory.
- Redirect in cycle N with no outstanding read -> imem_address=redirect_pc in N+1.
- Redirect during outstanding read -> new address issued cycle after the stale imem_resp; stale data never reaches fetch_valid.
- rst mid-transaction: state returns to REQ regardless; a later stale imem_resp for the aborted read is not tracked (memory is reset by the same rst).

## Test plan
- Reset, memory 1-cycle latency, ifid_en=1, word at 0x60 = 0x00000013 -> requests 0x60, 0x64, 0x68; fetch_pc 0x60 with next_pc 0x64, pred 0.
- Backward branch 0xFE000EE3 (beq x0,x0,-4) at 0x68 -> fetch_next_pc=0x64, pred=1, next imem_address=0x64.
- JAL 0x0100006F at 0x60 -> next_pc=0x70, pred=1; PREDICT_EN=0 -> next_pc=0x64, pred=0.
- HELD with ifid_en=0 for 5 cycles -> outputs stable, imem_read=0; then ifid_en=1 -> advances once.
- 4-cycle memory, redirect to 0x200 in cycle 2 of read at 0x64 -> address stays 0x64 until resp, data dropped, fetch_valid=0, then request 0x200.
- Redirect same cycle as imem_resp, and redirect while HELD -> fetch_valid=0 that cycle, next imem_address=redirect_pc.

Source files
------------

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: instruction-memory handshake, EX redirect, IF/ID producer side.
interface fetch_unit_if;
    logic        imem_read;
    logic [31:0] imem_address;
    logic        imem_resp;
    logic [31:0] imem_rdata;
    logic        ifid_en;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        fetch_valid;
    logic [31:0] fetch_pc;
    logic [31:0] fetch_pc_plus4;
    logic [31:0] fetch_next_pc;
    logic [31:0] fetch_rdata;
    logic        fetch_predicted_direction;

    // Fetch unit side.
    modport master (
        output imem_read, imem_address,
        input  imem_resp, imem_rdata,
        input  ifid_en, redirect, redirect_pc,
        output fetch_valid, fetch_pc, fetch_pc_plus4, fetch_next_pc,
        output fetch_rdata, fetch_predicted_direction
    );

    // Memory / pipeline side.
    modport slave (
        input  imem_read, imem_address,
        output imem_resp, imem_rdata,
        output ifid_en, redirect, redirect_pc,
        input  fetch_valid, fetch_pc, fetch_pc_plus4, fetch_next_pc,
        input  fetch_rdata, fetch_predicted_direction
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues word reads, buffers one fetched
// instruction with its static BTFN/JAL prediction, and handles EX redirects,
// including redirects that land while a read is still outstanding.
module fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h60,
    parameter bit          PREDICT_EN = 1'b1
) (
    input logic         clk,
    input logic         rst,
    fetch_unit_if.master bus
);

    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    typedef enum logic [1:0] {
        REQ,
        HELD,
        DROP
    } state_e;

    state_e      state_q;
    logic [31:0] pc_q;
    logic [31:0] pending_pc_q;
    logic [31:0] buf_pc_q;
    logic [31:0] buf_pc_plus4_q;
    logic [31:0] buf_next_pc_q;
    logic [31:0] buf_rdata_q;
    logic        buf_pred_q;

    logic [6:0]  opcode;
    logic [31:0] b_imm;
    logic [31:0] j_imm;
    logic [31:0] pc_plus4;
    logic [31:0] pred_next_d;
    logic        pred_taken_d;

    // Static prediction on the word arriving from memory, relative to pc_q.
    always_comb begin
        opcode       = bus.imem_rdata[6:0];
        b_imm        = {{19{bus.imem_rdata[31]}}, bus.imem_rdata[31], bus.imem_rdata[7],
                        bus.imem_rdata[30:25], bus.imem_rdata[11:8], 1'b0};
        j_imm        = {{11{bus.imem_rdata[31]}}, bus.imem_rdata[31], bus.imem_rdata[19:12],
                        bus.imem_rdata[20], bus.imem_rdata[30:21], 1'b0};
        pc_plus4     = pc_q + 32'd4;
        pred_taken_d = 1'b0;
        pred_next_d  = pc_plus4;
        if (PREDICT_EN) begin
            if (opcode == OP_BRANCH && bus.imem_rdata[31]) begin
                pred_taken_d = 1'b1;
                pred_next_d  = pc_q + b_imm;
            end else if (opcode == OP_JAL) begin
                pred_taken_d = 1'b1;
                pred_next_d  = pc_q + j_imm;
            end
        end
    end

    // pc_q is left untouched in DROP so it doubles as the frozen address of
    // the stale read; the redirect target waits in pending_pc_q.
    assign bus.imem_read    = !rst && (state_q != HELD);
    assign bus.imem_address = pc_q;
    assign bus.fetch_valid  = !rst && (state_q == HELD) && !bus.redirect;

    assign bus.fetch_pc                  = buf_pc_q;
    assign bus.fetch_pc_plus4            = buf_pc_plus4_q;
    assign bus.fetch_next_pc             = buf_next_pc_q;
    assign bus.fetch_rdata               = buf_rdata_q;
    assign bus.fetch_predicted_direction = buf_pred_q;

    // Fetch FSM: request, hold for IF/ID, or drain a read made stale by a redirect.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= REQ;
            pc_q           <= RESET_PC;
            pending_pc_q   <= RESET_PC;
            buf_pc_q       <= RESET_PC;
            buf_pc_plus4_q <= RESET_PC + 32'd4;
            buf_next_pc_q  <= RESET_PC + 32'd4;
            buf_rdata_q    <= '0;
            buf_pred_q     <= 1'b0;
        end else begin
            case (state_q)
                REQ: begin
                    if (bus.redirect) begin
                        if (bus.imem_resp) begin
                            pc_q <= bus.redirect_pc;
                        end else begin
                            pending_pc_q <= bus.redirect_pc;
                            state_q      <= DROP;
                        end
                    end else if (bus.imem_resp) begin
                        buf_pc_q       <= pc_q;
                        buf_pc_plus4_q <= pc_plus4;
                        buf_next_pc_q  <= pred_next_d;
                        buf_rdata_q    <= bus.imem_rdata;
                        buf_pred_q     <= pred_taken_d;
                        state_q        <= HELD;
                    end
                end
                HELD: begin
                    if (bus.redirect) begin
                        pc_q    <= bus.redirect_pc;
                        state_q <= REQ;
                    end else if (bus.ifid_en) begin
                        pc_q    <= buf_next_pc_q;
                        state_q <= REQ;
                    end
                end
                DROP: begin
                    if (bus.imem_resp) begin
                        pc_q    <= bus.redirect ? bus.redirect_pc : pending_pc_q;
                        state_q <= REQ;
                    end else if (bus.redirect) begin
                        pending_pc_q <= bus.redirect_pc;
                    end
                end
                default: state_q <= REQ;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus randomized traffic, checked
// against a transaction-level model of the fetch stream.
module tb_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h60;

    logic clk = 1'b0;
    logic rst;

    fetch_unit_if bus ();
    fetch_unit_if bus_np ();

    fetch_unit #(.RESET_PC(RST_PC), .PREDICT_EN(1'b1)) u_dut (.clk(clk), .rst(rst), .bus(bus));
    fetch_unit #(.RESET_PC(RST_PC), .PREDICT_EN(1'b0)) u_np  (.clk(clk), .rst(rst), .bus(bus_np));

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] mem_ovr [logic [31:0]];
    int unsigned lat_min = 1;
    int unsigned lat_max = 1;

    // Memory / model state
    bit          inflight;
    bit          inf_squash;
    logic [31:0] inf_addr;
    int unsigned inf_left;
    bit          held;
    logic [31:0] held_pc;
    logic [31:0] exp_fetch;

    logic [31:0] req_q[$];
    logic [31:0] acc_pc_q[$];
    logic [31:0] acc_next_q[$];
    logic [31:0] acc_pred_q[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] h;
        logic [6:0]  op;
        if (mem_ovr.exists(a)) return mem_ovr[a];
        h = (a ^ 32'h5bd1e995) * 32'h9E3779B1;
        h = h ^ (h >> 15);
        case (h[2:0])
            3'd0, 3'd1: op = 7'h63;
            3'd2:       op = 7'h6F;
            3'd3:       op = 7'h67;
            3'd4:       op = 7'h13;
            3'd5:       op = 7'h33;
            default:    op = h[13:7];
        endcase
        return {h[31:7], op};
    endfunction

    // Backward conditional branches and JAL are taken; everything else falls through.
    function automatic void predict(input logic [31:0] pc, input logic [31:0] w,
                                    output logic [31:0] nxt, output logic tk);
        int off;
        nxt = pc + 32'd4;
        tk  = 1'b0;
        if (w[6:0] == 7'h63 && w[31]) begin
            off = 2 * int'(w[11:8]) + 32 * int'(w[30:25]) + 2048 * int'(w[7]) - 4096;
            nxt = pc + 32'(off);
            tk  = 1'b1;
        end else if (w[6:0] == 7'h6F) begin
            off = 2 * int'(w[30:21]) + 2048 * int'(w[20]) + 4096 * int'(w[19:12])
                  - (w[31] ? (1 << 20) : 0);
            nxt = pc + 32'(off);
            tk  = 1'b1;
        end
    endfunction

    task automatic clear_logs();
        req_q.delete();
        acc_pc_q.delete();
        acc_next_q.delete();
        acc_pred_q.delete();
    endtask

    task automatic do_reset();
        rst                = 1'b1;
        bus.imem_resp      = 1'b0;
        bus.imem_rdata     = '0;
        bus.redirect       = 1'b0;
        bus.redirect_pc    = '0;
        bus.ifid_en        = 1'b0;
        bus_np.imem_resp   = 1'b0;
        bus_np.imem_rdata  = '0;
        bus_np.redirect    = 1'b0;
        bus_np.redirect_pc = '0;
        bus_np.ifid_en     = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_read",     32'(bus.imem_read), 32'd0);
        chk("rst_valid",    32'(bus.fetch_valid), 32'd0);
        chk("rst_buf_pc",   bus.fetch_pc, RST_PC);
        chk("rst_buf_pc4",  bus.fetch_pc_plus4, RST_PC + 32'd4);
        chk("rst_buf_next", bus.fetch_next_pc, RST_PC + 32'd4);
        chk("rst_buf_data", bus.fetch_rdata, 32'd0);
        chk("rst_buf_pred", 32'(bus.fetch_predicted_direction), 32'd0);
        rst       = 1'b0;
        inflight  = 1'b0;
        held      = 1'b0;
        exp_fetch = RST_PC;
        #1;
    endtask

    // One clock cycle: observe the request side, drive this cycle's inputs,
    // check the IF/ID side, then advance the model.
    task automatic step(input bit redir, input logic [31:0] rpc, input bit en);
        bit          resp;
        bit          acc;
        logic [31:0] nxt;
        logic        tk;
        logic [31:0] w;
        nxt = '0;
        tk  = 1'b0;
        chk("imem_read", 32'(bus.imem_read), 32'(!held));
        if (inflight) begin
            chk("addr_stable", bus.imem_address, inf_addr);
        end else if (!held && bus.imem_read) begin
            chk("req_addr", bus.imem_address, exp_fetch);
            req_q.push_back(bus.imem_address);
            inflight   = 1'b1;
            inf_squash = 1'b0;
            inf_addr   = bus.imem_address;
            inf_left   = $urandom_range(lat_max, lat_min);
        end
        resp            = inflight && (inf_left == 1);
        bus.redirect    = redir;
        bus.redirect_pc = rpc;
        bus.ifid_en     = en;
        bus.imem_resp   = resp;
        bus.imem_rdata  = resp ? mem_word(inf_addr) : $urandom();
        #1;
        chk("fetch_valid", 32'(bus.fetch_valid), 32'(held && !redir));
        if (held && !redir) begin
            w = mem_word(held_pc);
            predict(held_pc, w, nxt, tk);
            chk("fetch_pc",    bus.fetch_pc, held_pc);
            chk("fetch_pc4",   bus.fetch_pc_plus4, held_pc + 32'd4);
            chk("fetch_rdata", bus.fetch_rdata, w);
            chk("fetch_next",  bus.fetch_next_pc, nxt);
            chk("fetch_pred",  32'(bus.fetch_predicted_direction), 32'(tk));
        end
        acc = held && !redir && en;
        if (acc) begin
            acc_pc_q.push_back(held_pc);
            acc_next_q.push_back(nxt);
            acc_pred_q.push_back(32'(tk));
            held      = 1'b0;
            exp_fetch = nxt;
        end
        if (resp) begin
            if (!inf_squash && !redir) begin
                held    = 1'b1;
                held_pc = inf_addr;
            end
            inflight = 1'b0;
        end else if (inflight) begin
            inf_left--;
        end
        if (redir) begin
            held      = 1'b0;
            exp_fetch = rpc;
            if (inflight) inf_squash = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;

        // Straight-line code then a backward branch, single-cycle memory.
        mem_ovr.delete();
        mem_ovr[32'h60] = 32'h00000013;
        mem_ovr[32'h64] = 32'h00000013;
        mem_ovr[32'h68] = 32'hFE000EE3;
        lat_min = 1; lat_max = 1;
        do_reset();
        clear_logs();
        for (int i = 0; i < 8; i++) step(1'b0, '0, 1'b1);
        chk("t1_req0",  req_q[0], 32'h60);
        chk("t1_req1",  req_q[1], 32'h64);
        chk("t1_req2",  req_q[2], 32'h68);
        chk("t1_req3",  req_q[3], 32'h64);
        chk("t1_pc0",   acc_pc_q[0], 32'h60);
        chk("t1_next0", acc_next_q[0], 32'h64);
        chk("t1_pred0", acc_pred_q[0], 32'd0);
        chk("t1_pc2",   acc_pc_q[2], 32'h68);
        chk("t1_next2", acc_next_q[2], 32'h64);
        chk("t1_pred2", acc_pred_q[2], 32'd1);

        // JAL at reset PC, with and without prediction.
        mem_ovr.delete();
        mem_ovr[32'h60] = 32'h0100006F;
        do_reset();
        clear_logs();
        chk("np_read", 32'(bus_np.imem_read), 32'd1);
        chk("np_addr", bus_np.imem_address, 32'h60);
        bus_np.imem_resp  = 1'b1;
        bus_np.imem_rdata = 32'h0100006F;
        step(1'b0, '0, 1'b1);
        bus_np.imem_resp  = 1'b0;
        chk("np_valid", 32'(bus_np.fetch_valid), 32'd1);
        chk("np_pc",    bus_np.fetch_pc, 32'h60);
        chk("np_next",  bus_np.fetch_next_pc, 32'h64);
        chk("np_pred",  32'(bus_np.fetch_predicted_direction), 32'd0);
        chk("np_rdata", bus_np.fetch_rdata, 32'h0100006F);
        step(1'b0, '0, 1'b1);
        step(1'b0, '0, 1'b1);
        chk("t2_next", acc_next_q[0], 32'h70);
        chk("t2_pred", acc_pred_q[0], 32'd1);
        chk("t2_req1", req_q[1], 32'h70);

        // Stall in HELD for five cycles, then a single accept.
        mem_ovr.delete();
        mem_ovr[32'h60] = 32'h00000013;
        do_reset();
        clear_logs();
        step(1'b0, '0, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, '0, 1'b0);
        step(1'b0, '0, 1'b1);
        step(1'b0, '0, 1'b0);
        chk("t3_acc_cnt", 32'(acc_pc_q.size()), 32'd1);
        chk("t3_req_cnt", 32'(req_q.size()), 32'd2);
        chk("t3_req1",    req_q[1], 32'h64);

        // Four-cycle memory, redirect in the second cycle of the read at 0x64.
        lat_min = 4; lat_max = 4;
        do_reset();
        clear_logs();
        for (int i = 0; i < 6; i++) step(1'b0, '0, 1'b1);
        step(1'b1, 32'h200, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1);
        chk("t4_req_cnt", 32'(req_q.size()), 32'd3);
        chk("t4_req1",    req_q[1], 32'h64);
        chk("t4_req2",    req_q[2], 32'h200);
        chk("t4_acc_cnt", 32'(acc_pc_q.size()), 32'd1);

        // Redirect coinciding with a response, then redirect while HELD.
        lat_min = 2; lat_max = 2;
        do_reset();
        clear_logs();
        step(1'b0, '0, 1'b1);
        step(1'b1, 32'h300, 1'b1);
        step(1'b0, '0, 1'b1);
        step(1'b0, '0, 1'b1);
        step(1'b1, 32'h400, 1'b1);
        step(1'b0, '0, 1'b1);
        chk("t5_req1",    req_q[1], 32'h300);
        chk("t5_req2",    req_q[2], 32'h400);
        chk("t5_acc_cnt", 32'(acc_pc_q.size()), 32'd0);

        // Randomized traffic: variable latency, stalls, redirects, occasional reset.
        mem_ovr.delete();
        lat_min = 1; lat_max = 4;
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            bit          r;
            logic [31:0] a;
            bit          e;
            r = ($urandom_range(11, 0) == 0);
            a = $urandom() & 32'hFFFF_FFFC;
            e = ($urandom_range(9, 0) < 7);
            if ($urandom_range(299, 0) == 0) do_reset();
            else step(r, a, e);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
